// File: rtl/lsb_pkg.sv
// ---------------------------------------------------------------------------
// lsb_pkg
// Shared types and constants for the load/store buffer slice.
//   OPC_LOAD / OPC_STORE : RISC-V major opcodes; anything that is not a store
//                          is issued like a load.
//   lsb_state_t          : issue FSM states (DRAIN is only reachable when the
//                          design is built with LSB_FLUSH_EN).
//   lsb_entry_t          : one queued memory operation.
// ---------------------------------------------------------------------------
package lsb_pkg;

  localparam int ID_W = 5;
  localparam int XLEN = 32;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } lsb_state_t;

  typedef struct packed {
    logic [ID_W-1:0] ins_id;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic            committed;
  } lsb_entry_t;

  // Stores must wait for the ROB; every other opcode may issue immediately.
  function automatic logic is_store(input logic [6:0] opc);
    return opc == OPC_STORE;
  endfunction

endpackage

// File: rtl/lsb_ring.sv
// ---------------------------------------------------------------------------
// lsb_ring
// Circular entry storage with head/tail pointers and an occupancy count.
//   clk_in, rst_in   : clock, asynchronous active-low reset
//   enq_i            : write enq_entry_i at tail (committed bit forced to 0)
//   pop_i            : retire the head entry
//   clear_i          : drop every entry (head jumps to tail), wins over enq/pop
//   commit_mask_i    : per-slot set of the committed bit
//   head_entry_o     : entry at head
//   count_o          : number of live entries (0..DEPTH)
//   valid_o, ids_o   : per-slot occupancy and ROB tag, for commit matching
// ---------------------------------------------------------------------------
module lsb_ring
  import lsb_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             enq_i,
  input  lsb_entry_t       enq_entry_i,
  input  logic             pop_i,
  input  logic             clear_i,
  input  logic [DEPTH-1:0] commit_mask_i,
  output lsb_entry_t       head_entry_o,
  output logic [CNT_W-1:0] count_o,
  output logic [DEPTH-1:0] valid_o,
  output logic [ID_W-1:0]  ids_o [DEPTH]
);

  lsb_entry_t       entries_q [DEPTH];
  lsb_entry_t       entries_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] offset [DEPTH];

  // Commit bits are applied first so a fresh enqueue into the same slot
  // always starts uncommitted.
  always_comb begin
    entries_d = entries_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (commit_mask_i[i]) entries_d[i].committed = 1'b1;
    end
    if (clear_i) begin
      head_d  = tail_q;
      count_d = '0;
    end else begin
      if (enq_i) begin
        entries_d[tail_q]           = enq_entry_i;
        entries_d[tail_q].committed = 1'b0;
        tail_d                      = tail_q + PTR_W'(1);
      end
      if (pop_i) head_d = head_q + PTR_W'(1);
      case ({enq_i, pop_i})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      entries_q <= entries_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
    end
  end

  // A slot is live when its distance from head (mod DEPTH) is below count.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      offset[i]  = PTR_W'(i) - head_q;
      valid_o[i] = {1'b0, offset[i]} < count_q;
      ids_o[i]   = entries_q[i].ins_id;
    end
  end

  assign head_entry_o = entries_q[head_q];
  assign count_o      = count_q;

endmodule

// File: rtl/load_store_buffer.sv
// ---------------------------------------------------------------------------
// load_store_buffer
// In-order load/store queue in front of MemOperator. One request is in
// flight at a time; its completion is broadcast on the CDB one cycle later.
// Stores wait at the head until the ROB commits them.
//   clk_in, rst_in, rdy_in : clock, async active-low reset, global stall (low)
//   enq_*                  : entry input with valid/ready handshake
//   commit_valid/_ins_id   : ROB store-commit notice
//   have_ins + fields      : registered one-cycle request to MemOperator
//   alu_rdy/alu_res/res_ins_id : MemOperator completion
//   cdb_*                  : result broadcast
//   flush_in               : only with LSB_FLUSH_EN; drops all entries and
//                            discards the in-flight completion via DRAIN
// ---------------------------------------------------------------------------
module load_store_buffer
  import lsb_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            rdy_in,
  input  logic            enq_valid,
  output logic            enq_ready,
  input  logic [ID_W-1:0] enq_ins_id,
  input  logic [XLEN-1:0] enq_addr,
  input  logic [XLEN-1:0] enq_data,
  input  logic [6:0]      enq_opcode,
  input  logic [2:0]      enq_funct3,
  input  logic [6:0]      enq_funct7,
  input  logic            commit_valid,
  input  logic [ID_W-1:0] commit_ins_id,
  output logic            have_ins,
  output logic [ID_W-1:0] ins_id,
  output logic [XLEN-1:0] addr,
  output logic [XLEN-1:0] data,
  output logic [6:0]      opcode,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  input  logic            alu_rdy,
  input  logic [XLEN-1:0] alu_res,
  input  logic [ID_W-1:0] res_ins_id,
  output logic            cdb_valid,
  output logic [ID_W-1:0] cdb_ins_id,
  output logic [XLEN-1:0] cdb_data
`ifdef LSB_FLUSH_EN
  ,
  input  logic            flush_in
`endif
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  lsb_state_t       state_q, state_d;
  logic             have_ins_q, have_ins_d;
  logic [ID_W-1:0]  out_id_q, out_id_d;
  logic [XLEN-1:0]  addr_q, addr_d;
  logic [XLEN-1:0]  data_q, data_d;
  logic [6:0]       opcode_q, opcode_d;
  logic [2:0]       funct3_q, funct3_d;
  logic [6:0]       funct7_q, funct7_d;
  logic             cdb_valid_q, cdb_valid_d;
  logic [ID_W-1:0]  cdb_ins_id_q, cdb_ins_id_d;
  logic [XLEN-1:0]  cdb_data_q, cdb_data_d;

  logic             flush_act;
  logic             enq_fire;
  logic             pop;
  logic             clear;
  logic             full;
  logic             head_ready;
  logic             resp_match;
  lsb_entry_t       enq_entry;
  lsb_entry_t       head_entry;
  logic [CNT_W-1:0] count;
  logic [DEPTH-1:0] slot_valid;
  logic [ID_W-1:0]  slot_ids [DEPTH];
  logic [DEPTH-1:0] commit_mask;

`ifdef LSB_FLUSH_EN
  assign flush_act = flush_in;
`else
  assign flush_act = 1'b0;
`endif

  // Fullness is judged on the pre-pop count, so a full queue refuses an
  // enqueue even in the cycle its head retires.
  assign full      = (count == CNT_W'(DEPTH));
  assign enq_ready = rdy_in && !full && !flush_act;
  assign enq_fire  = enq_valid && enq_ready;

  // Out_id doubles as the registered ins_id request field.
  assign resp_match = alu_rdy && (res_ins_id == out_id_q);
  assign head_ready = (count != '0) && (!is_store(head_entry.opcode) || head_entry.committed);

  always_comb begin
    enq_entry           = '0;
    enq_entry.ins_id    = enq_ins_id;
    enq_entry.addr      = enq_addr;
    enq_entry.data      = enq_data;
    enq_entry.opcode    = enq_opcode;
    enq_entry.funct3    = enq_funct3;
    enq_entry.funct7    = enq_funct7;
  end

  // A commit tags every live entry with a matching ROB id.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      commit_mask[i] = rdy_in && commit_valid && slot_valid[i] && (slot_ids[i] == commit_ins_id);
    end
  end

  // Issue FSM. A flush overrides whatever the normal path decided this cycle,
  // including a completion that lands at the same edge.
  always_comb begin
    state_d      = state_q;
    have_ins_d   = 1'b0;
    out_id_d     = out_id_q;
    addr_d       = addr_q;
    data_d       = data_q;
    opcode_d     = opcode_q;
    funct3_d     = funct3_q;
    funct7_d     = funct7_q;
    cdb_valid_d  = 1'b0;
    cdb_ins_id_d = cdb_ins_id_q;
    cdb_data_d   = cdb_data_q;
    pop          = 1'b0;
    clear        = 1'b0;
    if (rdy_in) begin
      case (state_q)
        IDLE: begin
          if (head_ready) begin
            have_ins_d = 1'b1;
            out_id_d   = head_entry.ins_id;
            addr_d     = head_entry.addr;
            data_d     = head_entry.data;
            opcode_d   = head_entry.opcode;
            funct3_d   = head_entry.funct3;
            funct7_d   = head_entry.funct7;
            state_d    = WAIT;
          end
        end
        WAIT: begin
          if (resp_match) begin
            pop          = 1'b1;
            cdb_valid_d  = 1'b1;
            cdb_ins_id_d = out_id_q;
            cdb_data_d   = alu_res;
            state_d      = IDLE;
          end
        end
`ifdef LSB_FLUSH_EN
        DRAIN: begin
          if (resp_match) state_d = IDLE;
        end
`endif
        default: state_d = IDLE;
      endcase
`ifdef LSB_FLUSH_EN
      if (flush_in) begin
        have_ins_d   = 1'b0;
        out_id_d     = out_id_q;
        addr_d       = addr_q;
        data_d       = data_q;
        opcode_d     = opcode_q;
        funct3_d     = funct3_q;
        funct7_d     = funct7_q;
        cdb_valid_d  = 1'b0;
        cdb_ins_id_d = cdb_ins_id_q;
        cdb_data_d   = cdb_data_q;
        pop          = 1'b0;
        clear        = 1'b1;
        state_d      = (state_q == WAIT && !resp_match) ? DRAIN : IDLE;
      end
`endif
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q      <= IDLE;
      have_ins_q   <= 1'b0;
      out_id_q     <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      opcode_q     <= '0;
      funct3_q     <= '0;
      funct7_q     <= '0;
      cdb_valid_q  <= 1'b0;
      cdb_ins_id_q <= '0;
      cdb_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      have_ins_q   <= have_ins_d;
      out_id_q     <= out_id_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      opcode_q     <= opcode_d;
      funct3_q     <= funct3_d;
      funct7_q     <= funct7_d;
      cdb_valid_q  <= cdb_valid_d;
      cdb_ins_id_q <= cdb_ins_id_d;
      cdb_data_q   <= cdb_data_d;
    end
  end

  lsb_ring #(.DEPTH(DEPTH)) u_ring (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .enq_i         (enq_fire),
    .enq_entry_i   (enq_entry),
    .pop_i         (pop),
    .clear_i       (clear),
    .commit_mask_i (commit_mask),
    .head_entry_o  (head_entry),
    .count_o       (count),
    .valid_o       (slot_valid),
    .ids_o         (slot_ids)
  );

  assign have_ins   = have_ins_q;
  assign ins_id     = out_id_q;
  assign addr       = addr_q;
  assign data       = data_q;
  assign opcode     = opcode_q;
  assign funct3     = funct3_q;
  assign funct7     = funct7_q;
  assign cdb_valid  = cdb_valid_q;
  assign cdb_ins_id = cdb_ins_id_q;
  assign cdb_data   = cdb_data_q;

endmodule
